// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage for the Hack CPU. It sits directly downstream of the
// program counter, drives the PC value to a synchronous instruction ROM, tracks
// the read in flight and registers the returned instruction, together with its
// address, for decode/execute. A one-entry skid buffer absorbs the response
// already in flight when downstream stalls. Wrong-path fetches are discarded
// on a taken jump, and delivered instructions are counted.
//
// Ports
//   clk          single clock, rising-edge
//   reset        asynchronous, active-low reset (0 = reset)
//   pc_in        current PC value
//   pc_en        PC increment enable (a jump load in the PC still overrides it)
//   rom_addr     ROM read address, combinationally equal to pc_in
//   rom_data     ROM read data, valid the cycle after rom_addr is sampled
//   stall        downstream not ready
//   jump         taken jump this cycle (the PC loads its target on the same edge)
//   instr_out    fetched instruction
//   instr_pc     address of instr_out
//   instr_valid  instr_out / instr_pc hold a valid instruction
//   fetch_count  instructions accepted downstream (wraps)
//   fsm_state    current control state, for observation only
//
// Handshake: an instruction transfers downstream on every rising edge where
// instr_valid=1 and stall=0 (ready = ~stall). While instr_valid=1 and stall=1,
// instr_out and instr_pc hold stable. A stall with instr_valid=0 has no effect,
// and the stage keeps filling.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    input  logic               stall,
    input  logic               jump,
    output logic [DATA_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic [COUNT_W-1:0] fetch_count,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;

    logic hold;
    logic skid_fill;

    // Downstream is holding a presented instruction.
    assign hold      = stall & instr_valid;
    // The response already in flight has nowhere to go but the skid.
    assign skid_fill = hold & req_valid & ~jump;

    assign rom_addr  = pc_in;
    // Freezing the PC while held means at most one response lands after the
    // stall begins, so the single skid entry cannot overflow.
    assign pc_en     = (state != IDLE) & ~hold;
    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (skid_fill) state_nxt = HOLD;
            HOLD:    if (!stall) state_nxt = RUN;
            FLUSH:   state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (jump) begin
            state_nxt = FLUSH;
        end
    end

    // -------------------------------------------------------------------------
    // Request tracking, output register and skid buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid   <= 1'b0;
            req_pc      <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_pc     <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            // A request issued in the jump cycle is on the wrong path.
            req_valid <= pc_en & ~jump;
            req_pc    <= pc_in;

            if (jump) begin
                // Drop the presented instruction, the skid and the response
                // arriving now; the target shows up two edges later.
                instr_valid <= 1'b0;
                skid_valid  <= 1'b0;
            end else if (hold) begin
                if (req_valid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= rom_data;
                    skid_pc    <= req_pc;
                end
            end else if (skid_valid && !stall) begin
                instr_out   <= skid_data;
                instr_pc    <= skid_pc;
                instr_valid <= 1'b1;
                skid_valid  <= 1'b0;
            end else begin
                instr_out   <= rom_data;
                instr_pc    <= req_pc;
                instr_valid <= req_valid;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Delivered-instruction counter (wraps)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (instr_valid && !stall && !jump) begin
            fetch_count <= fetch_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 16;
  localparam int COUNT_W = 4;
  localparam int W       = ADDR_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc;
  logic               pc_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data;
  logic               stall;
  logic               jump;
  logic [ADDR_W-1:0]  jump_tgt;
  logic [DATA_W-1:0]  instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic [COUNT_W-1:0] fetch_count;
  logic [1:0]         fsm_state;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc),
    .pc_en       (pc_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .stall       (stall),
    .jump        (jump),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_count (fetch_count),
    .fsm_state   (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Environment models: synchronous ROM and program counter
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 | {4'h0, a[11:0]};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset)      pc <= '0;
    else if (jump)   pc <= jump_tgt;
    else if (pc_en)  pc <= pc + 15'd1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0]       exp_q[$];
  logic [COUNT_W-1:0] exp_cnt;
  int                 total = 0;
  int                 bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a);
    exp_q.push_back({a, rom_word(a)});
  endtask

  // Monitor: samples on the falling edge what the next rising edge will see.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      exp_cnt = '0;
    end else begin
      check("fetch_count", 32'(fetch_count), 32'(exp_cnt));
      if (instr_valid && !stall && !jump) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_delivery: got pc=%0h instr=%0h expected nothing", instr_pc, instr_out);
        end else begin
          e = exp_q.pop_front();
          check("delivered", 32'({instr_pc, instr_out}), 32'(e));
        end
        exp_cnt = exp_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    jump  = 1'b0;
    step();
    step();
    exp_q.delete();
    check("rst_instr_out", 32'(instr_out), 32'h0);
    check("rst_instr_pc", 32'(instr_pc), 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_count", 32'(fetch_count), 32'h0);
    check("rst_pc_en", 32'(pc_en), 32'h0);
  endtask

  // Release reset and check the startup latency: one IDLE cycle, one cycle
  // for the ROM read, then pc 0 is presented.
  task automatic start_seq(input int n);
    for (int i = 0; i < n; i++) push(ADDR_W'(i));
    reset = 1'b1;
    #1;
    check("idle_pc_en", 32'(pc_en), 32'h0);
    step();
    check("start_valid0", 32'(instr_valid), 32'h0);
    step();
    check("start_valid1", 32'(instr_valid), 32'h0);
    step();
    check("start_valid2", 32'(instr_valid), 32'h1);
    check("start_pc", 32'(instr_pc), 32'h0);
    check("start_instr", 32'(instr_out), 32'hA000);
  endtask

  task automatic wait_pc(input logic [ADDR_W-1:0] a);
    int n = 0;
    while (!(instr_valid && instr_pc == a) && n < 100) begin
      step();
      n++;
    end
    check("wait_pc_timeout", 32'(instr_valid && instr_pc == a), 32'h1);
  endtask

  // Wait for the expected queue to empty, then stall so nothing else is taken.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    stall = 1'b1;
  endtask

  task automatic jump_test(input logic [ADDR_W-1:0] trig, input logic [ADDR_W-1:0] tgt,
                           input bit pre_stall);
    wait_pc(trig);
    if (pre_stall) begin
      stall = 1'b1;
      step();
      check("pre_jump_hold_pc", 32'(instr_pc), 32'(trig));
      check("pre_jump_hold_valid", 32'(instr_valid), 32'h1);
    end
    jump     = 1'b1;
    jump_tgt = tgt;
    step();
    jump  = 1'b0;
    stall = 1'b0;
    check("bubble0_valid", 32'(instr_valid), 32'h0);
    step();
    check("bubble1_valid", 32'(instr_valid), 32'h0);
    step();
    check("target_valid", 32'(instr_valid), 32'h1);
    check("target_pc", 32'(instr_pc), 32'(tgt));
    check("target_instr", 32'(instr_out), 32'(rom_word(tgt)));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    jump     = 1'b0;
    jump_tgt = '0;
    do_reset();

    // Startup and sequential stream; 20 deliveries wrap the 4-bit counter.
    start_seq(20);
    drain();
    check("count_wrap", 32'(fetch_count), 32'h4);
    do_reset();

    // Three-cycle stall while pc 5 is presented.
    start_seq(10);
    wait_pc(15'd5);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_pc_en", 32'(pc_en), 32'h0);
      check("stall_pc", 32'(instr_pc), 32'h5);
      check("stall_instr", 32'(instr_out), 32'hA005);
      check("stall_valid", 32'(instr_valid), 32'h1);
      step();
    end
    stall = 1'b0;
    step();
    check("unstall_pc6", 32'({instr_valid, instr_pc}), 32'({1'b1, 15'd6}));
    step();
    check("unstall_pc7", 32'({instr_valid, instr_pc}), 32'({1'b1, 15'd7}));
    drain();
    do_reset();

    // Jump at pc 4 to 0x2AAA.
    start_seq(4);
    push(15'h2AAA);
    push(15'h2AAB);
    push(15'h2AAC);
    jump_test(15'd4, 15'h2AAA, 1'b0);
    drain();
    do_reset();

    // Jump together with stall while the skid is full.
    start_seq(5);
    push(15'h0100);
    push(15'h0101);
    push(15'h0102);
    jump_test(15'd5, 15'h0100, 1'b1);
    drain();
    do_reset();

    // Sequential fetch across the top of the address space.
    start_seq(2);
    push(15'h7FFE);
    push(15'h7FFF);
    push(15'h0000);
    push(15'h0001);
    jump_test(15'd2, 15'h7FFE, 1'b0);
    drain();
    do_reset();

    // Reset in the middle of a stall with the skid full, then a clean restart.
    start_seq(5);
    wait_pc(15'd5);
    stall = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    check("async_instr_out", 32'(instr_out), 32'h0);
    check("async_instr_pc", 32'(instr_pc), 32'h0);
    check("async_valid", 32'(instr_valid), 32'h0);
    check("async_count", 32'(fetch_count), 32'h0);
    check("async_pc_en", 32'(pc_en), 32'h0);
    check("async_queue", 32'(exp_q.size()), 32'h0);
    stall = 1'b0;
    step();
    step();
    start_seq(6);
    drain();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
